uart_tx_fifo_sched: RTL and testbench

//  Single-clock write/read controller for the UART TX byte FIFO memory. Accepts bytes from the bus side,

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_sched_if.sv | 63 ++++++
 rtl/uart_fifo_ptr_flags.sv | 60 ++++++
 rtl/uart_tx_fifo_sched.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo_sched.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART TX byte FIFO scheduler.
// Holds the scheduler state encoding and the UART data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        TXS_IDLE,
        TXS_LOAD,
        TXS_START,
        TXS_WAIT_BUSY,
        TXS_WAIT_DONE
    } tx_sched_state_e;

endpackage

// File: rtl/uart_tx_fifo_sched_if.sv
// Bus, RAM and uart_tx side signals of the TX FIFO scheduler.
// slave = scheduler side, master = parent / testbench side.
interface uart_tx_fifo_sched_if #(
    parameter int PTR_WIDTH = 4
);
    import uart_pkg::*;

    logic                   i_tx_sched_wr_en;
    logic [UART_DATA_W-1:0] i_tx_sched_wdata;
    logic                   i_tx_sched_flush;
    logic                   i_tx_sched_tx_busy;
    logic                   o_tx_sched_tx_start;
    logic [UART_DATA_W-1:0] o_tx_sched_tx_data;
    logic [UART_DATA_W-1:0] o_tx_sched_mem_wdata;
    logic                   o_tx_sched_mem_wen;
    logic [PTR_WIDTH-2:0]   o_tx_sched_mem_waddr;
    logic [PTR_WIDTH-2:0]   o_tx_sched_mem_raddr;
    logic [UART_DATA_W-1:0] i_tx_sched_mem_rdata;
    logic                   o_tx_sched_full;
    logic                   o_tx_sched_empty;
    logic                   o_tx_sched_almost_full;
    logic [PTR_WIDTH-1:0]   o_tx_sched_count;
    logic                   o_tx_sched_overflow;

    modport slave (
        input  i_tx_sched_wr_en,
        input  i_tx_sched_wdata,
        input  i_tx_sched_flush,
        input  i_tx_sched_tx_busy,
        input  i_tx_sched_mem_rdata,
        output o_tx_sched_tx_start,
        output o_tx_sched_tx_data,
        output o_tx_sched_mem_wdata,
        output o_tx_sched_mem_wen,
        output o_tx_sched_mem_waddr,
        output o_tx_sched_mem_raddr,
        output o_tx_sched_full,
        output o_tx_sched_empty,
        output o_tx_sched_almost_full,
        output o_tx_sched_count,
        output o_tx_sched_overflow
    );

    modport master (
        output i_tx_sched_wr_en,
        output i_tx_sched_wdata,
        output i_tx_sched_flush,
        output i_tx_sched_tx_busy,
        output i_tx_sched_mem_rdata,
        input  o_tx_sched_tx_start,
        input  o_tx_sched_tx_data,
        input  o_tx_sched_mem_wdata,
        input  o_tx_sched_mem_wen,
        input  o_tx_sched_mem_waddr,
        input  o_tx_sched_mem_raddr,
        input  o_tx_sched_full,
        input  o_tx_sched_empty,
        input  o_tx_sched_almost_full,
        input  o_tx_sched_count,
        input  o_tx_sched_overflow
    );

endinterface

// File: rtl/uart_fifo_ptr_flags.sv
// FIFO read/write pointers with wrap bit, occupancy and status flags.
// Flags derive only from the registered pointers.
module uart_fifo_ptr_flags #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 flush,
    input  logic                 pop,
    output logic                 push_ok,
    output logic [PTR_WIDTH-1:0] wptr,
    output logic [PTR_WIDTH-1:0] rptr,
    output logic [PTR_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH-1:0] AF_CNT = PTR_WIDTH'(AF_LEVEL);
    localparam logic [PTR_WIDTH-1:0] ONE    = PTR_WIDTH'(1);

    logic msb_diff;
    logic low_eq;

    // Status flags from the current pointer pair.
    always_comb begin
        msb_diff    = wptr[PTR_WIDTH-1] != rptr[PTR_WIDTH-1];
        low_eq      = wptr[PTR_WIDTH-2:0] == rptr[PTR_WIDTH-2:0];
        empty       = (wptr == rptr);
        full        = msb_diff && low_eq;
        count       = wptr - rptr;
        almost_full = (count >= AF_CNT);
        push_ok     = wr_en && !full && !flush;
    end

    // Pointer advance, flush clear and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + ONE;
            if (pop)
                rptr <= rptr + ONE;
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_sched.sv
// UART TX FIFO controller: push side, RAM pointers and a
// frame-at-a-time drain into uart_tx over start/busy.
module uart_tx_fifo_sched
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2
) (
    input  logic               i_tx_sched_clk,
    input  logic               i_tx_sched_rst,
    uart_tx_fifo_sched_if.slave bus
);

    tx_sched_state_e        state;
    tx_sched_state_e        state_nx;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   pop;
    logic                   push_ok;
    logic [PTR_WIDTH-1:0]   wptr;
    logic [PTR_WIDTH-1:0]   rptr;
    logic [PTR_WIDTH-1:0]   count;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   overflow;

    uart_fifo_ptr_flags #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH),
        .AF_LEVEL   (AF_LEVEL)
    ) u_ptr (
        .clk         (i_tx_sched_clk),
        .rst         (i_tx_sched_rst),
        .wr_en       (bus.i_tx_sched_wr_en),
        .flush       (bus.i_tx_sched_flush),
        .pop         (pop),
        .push_ok     (push_ok),
        .wptr        (wptr),
        .rptr        (rptr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    // Next state; a flush cancels a pending pop, not a started frame.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            TXS_IDLE: begin
                if (!empty && !bus.i_tx_sched_tx_busy &&
                    !bus.i_tx_sched_flush)
                    state_nx = TXS_LOAD;
            end
            TXS_LOAD: begin
                if (bus.i_tx_sched_flush) begin
                    state_nx = TXS_IDLE;
                end else begin
                    pop      = 1'b1;
                    state_nx = TXS_START;
                end
            end
            TXS_START: state_nx = TXS_WAIT_BUSY;
            TXS_WAIT_BUSY: begin
                if (bus.i_tx_sched_tx_busy)
                    state_nx = TXS_WAIT_DONE;
            end
            TXS_WAIT_DONE: begin
                if (!bus.i_tx_sched_tx_busy)
                    state_nx = TXS_IDLE;
            end
            default: state_nx = TXS_IDLE;
        endcase
    end

    // State register and output byte capture on pop.
    always_ff @(posedge i_tx_sched_clk or posedge i_tx_sched_rst) begin
        if (i_tx_sched_rst) begin
            state   <= TXS_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_nx;
            if (pop)
                tx_data <= bus.i_tx_sched_mem_rdata;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.o_tx_sched_tx_start    = (state == TXS_START);
        bus.o_tx_sched_tx_data     = tx_data;
        bus.o_tx_sched_mem_wdata   = bus.i_tx_sched_wdata;
        bus.o_tx_sched_mem_wen     = push_ok;
        bus.o_tx_sched_mem_waddr   = wptr[PTR_WIDTH-2:0];
        bus.o_tx_sched_mem_raddr   = rptr[PTR_WIDTH-2:0];
        bus.o_tx_sched_full        = full;
        bus.o_tx_sched_empty       = empty;
        bus.o_tx_sched_almost_full = almost_full;
        bus.o_tx_sched_count       = count;
        bus.o_tx_sched_overflow    = overflow;
    end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Testbench for uart_tx_fifo_sched with RAM and uart_tx models.
// Expected bytes are queued on push and compared on tx_start.
module tb_uart_tx_fifo_sched;
    import uart_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 4;

    logic clk;
    logic rst;
    logic busy_force;
    logic auto_uart;
    int   model_cnt;
    logic model_busy;
    logic [7:0] mem [DEPTH];
    logic [7:0] exp_q [$];
    int   n_tests;
    int   n_fail;

    uart_tx_fifo_sched_if #(.PTR_WIDTH(PW)) bus ();

    uart_tx_fifo_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .i_tx_sched_clk (clk),
        .i_tx_sched_rst (rst),
        .bus            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign model_busy = (model_cnt != 0);
    assign bus.i_tx_sched_tx_busy = busy_force | model_busy;
    assign bus.i_tx_sched_mem_rdata = mem[bus.o_tx_sched_mem_raddr];

    always @(posedge clk)
        if (bus.o_tx_sched_mem_wen)
            mem[bus.o_tx_sched_mem_waddr] <= bus.o_tx_sched_mem_wdata;

    always @(posedge clk or posedge rst)
        if (rst)
            model_cnt <= 0;
        else if (auto_uart && bus.o_tx_sched_tx_start)
            model_cnt <= 10;
        else if (model_cnt > 0)
            model_cnt <= model_cnt - 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && bus.o_tx_sched_tx_start) begin
            if (exp_q.size() == 0)
                check("unexpected_start", 32'd1, 32'd0);
            else
                check("tx_data", 32'(bus.o_tx_sched_tx_data),
                      32'(exp_q.pop_front()));
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit queue_it);
        bus.i_tx_sched_wr_en = 1'b1;
        bus.i_tx_sched_wdata = b;
        if (queue_it)
            exp_q.push_back(b);
        tick();
        bus.i_tx_sched_wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && !model_busy &&
                   (dut.state == TXS_IDLE) && bus.o_tx_sched_empty;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        busy_force = 1'b0;
        auto_uart  = 1'b0;
        bus.i_tx_sched_wr_en = 1'b0;
        bus.i_tx_sched_wdata = 8'h00;
        bus.i_tx_sched_flush = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // idle after reset
        repeat (10) tick();
        @(negedge clk);
        check("rst_empty", 32'(bus.o_tx_sched_empty), 32'd1);
        check("rst_count", 32'(bus.o_tx_sched_count), 32'd0);
        check("rst_full", 32'(bus.o_tx_sched_full), 32'd0);
        check("rst_af", 32'(bus.o_tx_sched_almost_full), 32'd0);
        check("rst_ovf", 32'(bus.o_tx_sched_overflow), 32'd0);
        check("rst_start", 32'(bus.o_tx_sched_tx_start), 32'd0);
        check("rst_txdata", 32'(bus.o_tx_sched_tx_data), 32'd0);
        check("rst_wen", 32'(bus.o_tx_sched_mem_wen), 32'd0);

        // single byte, latency to tx_start
        auto_uart = 1'b1;
        tick();
        bus.i_tx_sched_wr_en = 1'b1;
        bus.i_tx_sched_wdata = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        check("t2_wen", 32'(bus.o_tx_sched_mem_wen), 32'd1);
        check("t2_waddr", 32'(bus.o_tx_sched_mem_waddr), 32'd0);
        tick();
        bus.i_tx_sched_wr_en = 1'b0;
        @(negedge clk);
        check("t2_start_e1", 32'(bus.o_tx_sched_tx_start), 32'd0);
        check("t2_count", 32'(bus.o_tx_sched_count), 32'd1);
        tick();
        @(negedge clk);
        check("t2_start_e2", 32'(bus.o_tx_sched_tx_start), 32'd0);
        tick();
        @(negedge clk);
        check("t2_start_e3", 32'(bus.o_tx_sched_tx_start), 32'd1);
        check("t2_empty", 32'(bus.o_tx_sched_empty), 32'd1);
        wait_drain("t2_drain");

        // fill while busy, then overflow
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(8'h10 + i), 1'b1);
            @(negedge clk);
            check("t3_count", 32'(bus.o_tx_sched_count), 32'(i + 1));
            check("t3_af", 32'(bus.o_tx_sched_almost_full),
                  32'((i + 1) >= DEPTH - 2));
        end
        check("t3_full", 32'(bus.o_tx_sched_full), 32'd1);
        check("t3_ovf_pre", 32'(bus.o_tx_sched_overflow), 32'd0);
        push(8'h18, 1'b0);
        @(negedge clk);
        check("t3_ovf", 32'(bus.o_tx_sched_overflow), 32'd1);
        check("t3_count9", 32'(bus.o_tx_sched_count), 32'd8);

        // drain eight frames in order
        tick();
        busy_force = 1'b0;
        wait_drain("t4_drain");
        check("t4_count", 32'(bus.o_tx_sched_count), 32'd0);
        check("t4_raddr", 32'(bus.o_tx_sched_mem_raddr), 32'd1);
        check("t4_waddr", 32'(bus.o_tx_sched_mem_waddr), 32'd1);
        check("t4_ovf_sticky", 32'(bus.o_tx_sched_overflow), 32'd1);

        // push during LOAD while full, then flush
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push(8'(8'h20 + i), 1'b1);
        busy_force = 1'b0;
        tick();
        bus.i_tx_sched_wr_en = 1'b1;
        bus.i_tx_sched_wdata = 8'h99;
        @(negedge clk);
        check("t5_load", 32'(dut.state), 32'(TXS_LOAD));
        check("t5_full", 32'(bus.o_tx_sched_full), 32'd1);
        check("t5_wen", 32'(bus.o_tx_sched_mem_wen), 32'd0);
        tick();
        bus.i_tx_sched_wr_en = 1'b0;
        @(negedge clk);
        check("t5_count7", 32'(bus.o_tx_sched_count), 32'd7);
        check("t5_full_after", 32'(bus.o_tx_sched_full), 32'd0);
        tick();
        bus.i_tx_sched_flush = 1'b1;
        while (exp_q.size() > 0)
            void'(exp_q.pop_back());
        tick();
        bus.i_tx_sched_flush = 1'b0;
        @(negedge clk);
        check("t5_fl_count", 32'(bus.o_tx_sched_count), 32'd0);
        check("t5_fl_ovf", 32'(bus.o_tx_sched_overflow), 32'd0);
        check("t5_fl_empty", 32'(bus.o_tx_sched_empty), 32'd1);
        wait_drain("t5_drain");

        // async reset mid-frame
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++)
            push(8'(8'h30 + i), 1'b1);
        busy_force = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("t6_wdone", 32'(dut.state), 32'(TXS_WAIT_DONE));
        check("t6_count3", 32'(bus.o_tx_sched_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_state", 32'(dut.state), 32'(TXS_IDLE));
        check("t6_count", 32'(bus.o_tx_sched_count), 32'd0);
        check("t6_start", 32'(bus.o_tx_sched_tx_start), 32'd0);
        check("t6_empty", 32'(bus.o_tx_sched_empty), 32'd1);
        check("t6_txdata", 32'(bus.o_tx_sched_tx_data), 32'd0);
        while (exp_q.size() > 0)
            void'(exp_q.pop_back());
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("t6_post_empty", 32'(bus.o_tx_sched_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
